nrs_gold_seq_gen: RTL and testbench



---
 rtl/nrs_pkg.sv | 39 +++
 rtl/gold_lfsr_pair.sv | 52 +++++
 rtl/nrs_gold_seq_gen.sv | 202 ++++++++++++++++++++
 tb/tb_nrs_gold_seq_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nrs_pkg.sv
// Shared constants, widths and FSM state type for the NB-IoT NRS Gold
// sequence generator.
package nrs_pkg;

  // Gold sequence warm-up length.
  localparam int NC_DEFAULT       = 1600;
  // Maximum downlink bandwidth in resource blocks.
  localparam int NRB_MAX_DL       = 110;
  // Bits skipped after the warm-up, one QPSK symbol per RB below the maximum.
  localparam int M_OFFSET_DEFAULT = 2 * (NRB_MAX_DL - 1);
  // Bits handed to the QPSK mapper per cinit word.
  localparam int OUT_BITS_DEFAULT = 4;

  // Width of each of the two Gold sequence LFSRs.
  localparam int LFSR_W  = 31;
  // Width of the cinit word coming from the cinit generator.
  localparam int CINIT_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_EMIT = 2'd2
  } gold_state_e;

  // Counter width covering the skip count and the emit bit index.
  // Never returns less than 1, so a zero skip length still has a counter.
  function automatic int cnt_width(input int skip_len, input int out_bits);
    int w;
    w = $clog2(skip_len + 1);
    if ($clog2(out_bits + 1) > w) begin
      w = $clog2(out_bits + 1);
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/gold_lfsr_pair.sv
// The x1/x2 LFSR pair of the length-31 Gold sequence. Bit 0 of each
// register holds x(n); a step shifts right and feeds x(n+31) into bit 30.
module gold_lfsr_pair
  import nrs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] x2_init,
  output logic              c_bit
);

  logic [LFSR_W-1:0] x1_q;
  logic [LFSR_W-1:0] x1_d;
  logic [LFSR_W-1:0] x2_q;
  logic [LFSR_W-1:0] x2_d;
  logic              x1_fb;
  logic              x2_fb;

  // Feedback taps: x1(n+31) = x1(n+3)^x1(n), x2(n+31) = x2(n+3)^x2(n+2)^x2(n+1)^x2(n).
  assign x1_fb = x1_q[3] ^ x1_q[0];
  assign x2_fb = x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0];

  // Next state: load wins over step; otherwise hold.
  always_comb begin
    x1_d = x1_q;
    x2_d = x2_q;
    if (load) begin
      x1_d = LFSR_W'(1);
      x2_d = x2_init;
    end else if (step) begin
      x1_d = {x1_fb, x1_q[LFSR_W-1:1]};
      x2_d = {x2_fb, x2_q[LFSR_W-1:1]};
    end
  end

  // State registers; reset puts x1 at its fixed seed and clears x2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_q <= LFSR_W'(1);
      x2_q <= '0;
    end else begin
      x1_q <= x1_d;
      x2_q <= x2_d;
    end
  end

  // Current Gold sequence bit c(n).
  assign c_bit = x1_q[0] ^ x2_q[0];

endmodule

// File: rtl/nrs_gold_seq_gen.sv
// NRS Gold sequence generator: buffers cinit words in a 2-entry FIFO,
// runs the Gold sequence past NC + M_OFFSET bits for each word and
// delivers the next OUT_BITS bits with a one-cycle c_valid pulse.
module nrs_gold_seq_gen
  import nrs_pkg::*;
#(
  parameter int NC       = NC_DEFAULT,
  parameter int M_OFFSET = M_OFFSET_DEFAULT,
  parameter int OUT_BITS = OUT_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cinit_valid,
  input  logic [CINIT_W-1:0]  cinit,
  output logic                cinit_ready,
  output logic [OUT_BITS-1:0] c_bits,
  output logic                c_valid,
  output logic                busy
);

  localparam int SKIP_LEN = NC + M_OFFSET;
  localparam int CNT_W    = cnt_width(SKIP_LEN, OUT_BITS);
  localparam int IDX_W    = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;

  // Terminal counts for the two counting states.
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((SKIP_LEN > 0) ? (SKIP_LEN - 1) : 0);
  localparam logic [CNT_W-1:0] EMIT_LAST = CNT_W'(OUT_BITS - 1);

  // State entered right after a load; a zero skip length goes straight to EMIT.
  localparam gold_state_e FIRST_ST = (SKIP_LEN == 0) ? ST_EMIT : ST_SKIP;

  // ------------------------------------------------------------------
  // Input FIFO
  // ------------------------------------------------------------------
  logic [CINIT_W-1:0] fifo_mem_q [2];
  logic [CINIT_W-1:0] fifo_mem_d [2];
  logic               wr_ptr_q;
  logic               wr_ptr_d;
  logic               rd_ptr_q;
  logic               rd_ptr_d;
  logic [1:0]         count_q;
  logic [1:0]         count_d;
  logic               push;
  logic               pop;

  // ------------------------------------------------------------------
  // Sequencer state
  // ------------------------------------------------------------------
  gold_state_e         state_q;
  gold_state_e         state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [OUT_BITS-1:0] shreg_q;
  logic [OUT_BITS-1:0] shreg_d;
  logic [OUT_BITS-1:0] c_bits_q;
  logic [OUT_BITS-1:0] c_bits_d;
  logic                c_valid_q;
  logic                c_valid_d;

  logic                lfsr_load;
  logic                lfsr_step;
  logic                c_bit;
  logic [LFSR_W-1:0]   x2_init;
  logic [IDX_W-1:0]    cap_idx;
  logic [OUT_BITS-1:0] cap_vec;

  // A word is taken whenever there is room; a pop happens only from IDLE.
  assign cinit_ready = (count_q != 2'd2);
  assign push        = cinit_valid && cinit_ready;
  assign pop         = (state_q == ST_IDLE) && (count_q != 2'd0);

  // Head of the FIFO, zero-extended to the LFSR width, seeds x2.
  assign x2_init = {{(LFSR_W - CINIT_W){1'b0}}, fifo_mem_q[rd_ptr_q]};

  // Per-entry write: only the slot under the write pointer takes the new word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
    assign fifo_mem_d[gi] = (push && (wr_ptr_q == 1'(gi))) ? cinit : fifo_mem_q[gi];

    // FIFO storage register for one entry.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        fifo_mem_q[gi] <= '0;
      end else begin
        fifo_mem_q[gi] <= fifo_mem_d[gi];
      end
    end
  end

  // Pointer and occupancy update; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ------------------------------------------------------------------
  // Gold sequence LFSRs
  // ------------------------------------------------------------------
  gold_lfsr_pair u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .x2_init (x2_init),
    .c_bit   (c_bit)
  );

  // The counter doubles as the output bit index while emitting.
  assign cap_idx = cnt_q[IDX_W-1:0];

  // Capture vector: the shift register with the current c(n) dropped into
  // the slot selected by the bit index.
  for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_capture
    assign cap_vec[gi] = (cap_idx == IDX_W'(gi)) ? c_bit : shreg_q[gi];
  end

  // Sequencer: load on pop, step through the skip region, then capture
  // OUT_BITS bits and publish them together with a single c_valid pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    c_bits_d  = c_bits_q;
    c_valid_d = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          lfsr_load = 1'b1;
          cnt_d     = '0;
          state_d   = FIRST_ST;
        end
      end
      ST_SKIP: begin
        lfsr_step = 1'b1;
        if (cnt_q == SKIP_LAST) begin
          cnt_d   = '0;
          state_d = ST_EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EMIT: begin
        lfsr_step = 1'b1;
        shreg_d   = cap_vec;
        if (cnt_q == EMIT_LAST) begin
          c_bits_d  = cap_vec;
          c_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      c_bits_q  <= '0;
      c_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      c_bits_q  <= c_bits_d;
      c_valid_q <= c_valid_d;
    end
  end

  assign c_bits  = c_bits_q;
  assign c_valid = c_valid_q;
  assign busy    = (state_q != ST_IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_nrs_gold_seq_gen.sv
// Directed bench for nrs_gold_seq_gen: a zero-skip instance checked against
// hand-derived bit patterns and a default instance checked against a
// reference Gold sequence built from the x1/x2 recurrences.
`timescale 1ns/1ps
module tb_nrs_gold_seq_gen;

  localparam int LAT      = 1823;  // acceptance edge to c_valid edge, defaults
  localparam int LAT0     = 5;     // same, NC = M_OFFSET = 0
  localparam int SKIP_DEF = 1818;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        cinit_valid = 1'b0;
  logic [27:0] cinit       = '0;
  logic        cinit_ready;
  logic [3:0]  c_bits;
  logic        c_valid;
  logic        busy;

  logic        cinit_valid0 = 1'b0;
  logic [27:0] cinit0       = '0;
  logic        cinit_ready0;
  logic [3:0]  c_bits0;
  logic        c_valid0;
  logic        busy0;

  int n_pass  = 0;
  int n_total = 0;

  int          edge_cnt = 0;
  int          out_edge_q [$];
  logic [3:0]  out_bits_q [$];
  logic [27:0] tab [16];

  always #5 clk = ~clk;

  nrs_gold_seq_gen dut (
    .clk         (clk),
    .rst         (rst),
    .cinit_valid (cinit_valid),
    .cinit       (cinit),
    .cinit_ready (cinit_ready),
    .c_bits      (c_bits),
    .c_valid     (c_valid),
    .busy        (busy)
  );

  nrs_gold_seq_gen #(
    .NC       (0),
    .M_OFFSET (0),
    .OUT_BITS (4)
  ) dut0 (
    .clk         (clk),
    .rst         (rst),
    .cinit_valid (cinit_valid0),
    .cinit       (cinit0),
    .cinit_ready (cinit_ready0),
    .c_bits      (c_bits0),
    .c_valid     (c_valid0),
    .busy        (busy0)
  );

  // Rising-edge counter used to time acceptance and output pulses.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Record every c_valid pulse of the default instance with its edge number.
  always @(negedge clk) begin
    if (c_valid === 1'b1) begin
      out_edge_q.push_back(edge_cnt);
      out_bits_q.push_back(c_bits);
    end
  end

  function automatic logic [27:0] nrs_cinit(input int nid, input int ns, input int l);
    return 28'(1024 * (7 * (ns + 1) + l + 1) * (2 * nid + 1) + 2 * nid + 1);
  endfunction

  // Reference: c(n) = x1(n) ^ x2(n), built from the sequence recurrences.
  function automatic logic [3:0] gold_ref(input logic [27:0] ci, input int skip);
    bit         x1 [1900];
    bit         x2 [1900];
    logic [3:0] r;
    for (int n = 0; n < 31; n++) begin
      x1[n] = (n == 0);
      x2[n] = (n < 28) ? ci[n] : 1'b0;
    end
    for (int n = 0; n + 31 < 1900; n++) begin
      x1[n + 31] = x1[n + 3] ^ x1[n];
      x2[n + 31] = x2[n + 3] ^ x2[n + 2] ^ x2[n + 1] ^ x2[n];
    end
    for (int i = 0; i < 4; i++) r[i] = x1[skip + i] ^ x2[skip + i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word through the zero-skip instance; called at a negedge.
  task automatic run0(input logic [27:0] w, input logic [3:0] exp_bits, input string tag);
    int n;
    chk({tag, "_ready"}, 32'(cinit_ready0), 32'd1);
    cinit0       = w;
    cinit_valid0 = 1'b1;
    @(negedge clk);
    cinit_valid0 = 1'b0;
    n = 0;
    while (c_valid0 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT0));
    chk({tag, "_bits"}, 32'(c_bits0), 32'(exp_bits));
    @(negedge clk);
  endtask

  // Offer a word to the default instance and hold it until accepted.
  task automatic offer(input logic [27:0] w, output int acc_edge);
    int guard;
    guard       = 0;
    cinit       = w;
    cinit_valid = 1'b1;
    while (cinit_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    acc_edge = edge_cnt + 1;
    @(negedge clk);
    cinit_valid = 1'b0;
  endtask

  // Take the next recorded output pulse, bounded in time.
  task automatic wait_out(output int e, output logic [3:0] b);
    int guard;
    guard = 0;
    while (out_edge_q.size() == 0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (out_edge_q.size() != 0) begin
      e = out_edge_q.pop_front();
      b = out_bits_q.pop_front();
    end else begin
      e = -1;
      b = 'x;
    end
  endtask

  initial begin
    int          a1, a2, a3, a4, e1, e2, e3, e4, k;
    logic [3:0]  b1, b2, b3, b4;
    k = 0;
    for (int nid = 0; nid < 4; nid++)
      for (int s = 0; s < 2; s++)
        for (int l = 5; l < 7; l++) begin
          tab[k] = nrs_cinit(nid, (s == 0) ? 0 : 19, l);
          k++;
        end

    // Reset values on both instances.
    repeat (2) @(negedge clk);
    chk("rst_c_bits",  32'(c_bits),       32'd0);
    chk("rst_c_valid", 32'(c_valid),      32'd0);
    chk("rst_busy",    32'(busy),         32'd0);
    chk("rst_ready",   32'(cinit_ready),  32'd1);
    chk("rst0_c_bits", 32'(c_bits0),      32'd0);
    chk("rst0_c_valid",32'(c_valid0),     32'd0);
    chk("rst0_busy",   32'(busy0),        32'd0);
    chk("rst0_ready",  32'(cinit_ready0), 32'd1);
    rst = 1'b1;

    // Zero skip: c(n) = x1(n)^x2(n) with x1 = 1,0,0,... and x2 = cinit bits.
    run0(28'h0, 4'b0001, "nc0_ci0");
    run0(28'h1, 4'b0000, "nc0_ci1");
    run0(28'hF, 4'b1110, "nc0_ciF");

    // Default parameters, one word at a time.
    for (int i = 0; i < 12; i++) begin
      offer(tab[i], a1);
      wait_out(e1, b1);
      chk($sformatf("single%0d_lat", i),  32'(e1 - a1), 32'(LAT));
      chk($sformatf("single%0d_bits", i), 32'(b1), 32'(gold_ref(tab[i], SKIP_DEF)));
      chk($sformatf("single%0d_idle", i), 32'(busy), 32'd0);
    end

    // Three consecutive words from idle (second one lands on the first pop),
    // then a fourth that must stall until the next pop.
    offer(tab[12], a1);
    offer(tab[13], a2);
    offer(tab[14], a3);
    chk("burst_acc2", 32'(a2), 32'(a1 + 1));
    chk("burst_acc3", 32'(a3), 32'(a1 + 2));
    chk("burst_full_ready", 32'(cinit_ready), 32'd0);
    offer(tab[15], a4);
    wait_out(e1, b1);
    wait_out(e2, b2);
    wait_out(e3, b3);
    wait_out(e4, b4);
    chk("burst_e1",   32'(e1), 32'(a1 + LAT));
    chk("burst_e2",   32'(e2), 32'(e1 + LAT));
    chk("burst_e3",   32'(e3), 32'(e2 + LAT));
    chk("burst_e4",   32'(e4), 32'(e3 + LAT));
    chk("burst_acc4", 32'(a4), 32'(e1 + 2));
    chk("burst_b1", 32'(b1), 32'(gold_ref(tab[12], SKIP_DEF)));
    chk("burst_b2", 32'(b2), 32'(gold_ref(tab[13], SKIP_DEF)));
    chk("burst_b3", 32'(b3), 32'(gold_ref(tab[14], SKIP_DEF)));
    chk("burst_b4", 32'(b4), 32'(gold_ref(tab[15], SKIP_DEF)));

    // Reset in the middle of SKIP with a second word buffered.
    offer(tab[3], a1);
    offer(tab[4], a2);
    while (edge_cnt < a1 + 901) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_c_bits",  32'(c_bits),      32'd0);
    chk("mid_rst_c_valid", 32'(c_valid),     32'd0);
    chk("mid_rst_busy",    32'(busy),        32'd0);
    chk("mid_rst_ready",   32'(cinit_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2000) @(negedge clk);
    chk("post_rst_no_out", 32'(out_edge_q.size()), 32'd0);
    offer(tab[5], a1);
    wait_out(e1, b1);
    chk("post_rst_lat",  32'(e1 - a1), 32'(LAT));
    chk("post_rst_bits", 32'(b1), 32'(gold_ref(tab[5], SKIP_DEF)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
